// File: rtl/store_lane_writer_pkg.sv
// Shared definitions for the store lane writer: store opcodes, FSM states
// and the request legality check.
package store_lane_writer_pkg;

    // Store opcode encoding as carried on req_op.
    typedef enum logic [1:0] {
        ST_SW  = 2'd0,
        ST_SH  = 2'd1,
        ST_SB  = 2'd2,
        ST_RSV = 2'd3
    } st_op_e;

    // Store sequencer states.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_WAIT_R = 3'd2,
        S_WRITE  = 3'd3,
        S_FIN    = 3'd4,
        S_FAIL   = 3'd5
    } st_state_e;

    // A request is rejected without touching memory when the opcode is
    // reserved or the address is not aligned to the access size.
    function automatic logic st_req_bad(input logic [1:0] op, input logic [1:0] lo);
        logic bad;
        case (op)
            ST_SW:   bad = (lo != 2'b00);
            ST_SH:   bad = lo[0];
            ST_SB:   bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: places the store data into its byte/halfword
// lane of the word read back from memory. SW passes the register through.
module store_lane_merge (
    input  logic [1:0]  op,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] merged
);
    import store_lane_writer_pkg::*;

    // Start from the memory word and overwrite only the addressed lane.
    always_comb begin
        merged = rdata;
        case (op)
            ST_SW:   merged = wdata;
            ST_SH:   merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            ST_SB:   merged[{lane, 3'b000} +: 8] = wdata[7:0];
            default: merged = rdata;
        endcase
    end

endmodule

// File: rtl/store_lane_writer.sv
// Store lane writer: narrows a 32-bit register store (SW/SH/SB) onto a
// word-only data memory. Sub-word stores use read-modify-write; all
// outputs are registered and a one-cycle done (with err) ends each request.
module store_lane_writer #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned RD_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              done,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid
);
    import store_lane_writer_pkg::*;

    localparam int unsigned      TMR_W    = $clog2(RD_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RD_TIMEOUT - 1);

    st_state_e         state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [1:0]        op_q;
    logic [1:0]        lane_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merged;

    logic              en_d, we_d, done_d, err_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       wdata_d;

    store_lane_merge u_merge (
        .op     (op_q),
        .lane   (lane_q),
        .wdata  (wdata_q),
        .rdata  (mem_rdata),
        .merged (merged)
    );

    // Next-state and next-output decode; outputs are computed for the state
    // being entered so that the registered strobes line up with that state.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        en_d    = 1'b0;
        we_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (st_req_bad(req_op, req_addr[1:0])) begin
                        state_d = S_FAIL;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        addr_d = {req_addr[ADDR_W-1:2], 2'b00};
                        en_d   = 1'b1;
                        if (req_op == ST_SW) begin
                            state_d = S_WRITE;
                            we_d    = 1'b1;
                            wdata_d = req_wdata;
                        end else begin
                            state_d = S_READ;
                        end
                    end
                end
            end
            S_READ: begin
                state_d = S_WAIT_R;
                timer_d = '0;
            end
            S_WAIT_R: begin
                if (mem_rvalid) begin
                    state_d = S_WRITE;
                    en_d    = 1'b1;
                    we_d    = 1'b1;
                    wdata_d = merged;
                end else if (timer_q == TMR_LAST) begin
                    state_d = S_FAIL;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    timer_d = timer_q + TMR_W'(1);
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_WRITE: begin
                state_d = S_FIN;
                done_d  = 1'b1;
            end
            S_FIN, S_FAIL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, timer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            req_ready <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            req_ready <= (state_d == S_IDLE);
            done      <= done_d;
            err       <= err_d;
            mem_en    <= en_d;
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
        end
    end

    // Capture the request payload on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            lane_q  <= '0;
            wdata_q <= '0;
        end else if (state_q == S_IDLE && req_valid) begin
            op_q    <= req_op;
            lane_q  <= req_addr[1:0];
            wdata_q <= req_wdata;
        end
    end

endmodule
